// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module   : mem_wb_stage_if
// Desc     : EX/MEM-to-MEM/WB bus bundle; optional misalign outputs follow
//            MEM_ALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
    logic [1:0]  WB_MEM;
    logic [1:0]  MEM_MEM;
    logic [4:0]  WN_MEM;
    logic [31:0] RD2_MEM;
    logic [31:0] DataOut_MEM;
    logic [1:0]  WB_WB;
    logic [4:0]  WN_WB;
    logic [31:0] RDATA_WB;
    logic [31:0] ALU_WB;
    logic [31:0] WData_WB;
`ifdef MEM_ALIGN_CHK_EN
    logic        Misalign_WB;
    logic        MisalignErr;
`endif

    modport master (
        output WB_MEM, MEM_MEM, WN_MEM, RD2_MEM, DataOut_MEM,
        input  WB_WB, WN_WB, RDATA_WB, ALU_WB, WData_WB
`ifdef MEM_ALIGN_CHK_EN
        , input Misalign_WB, MisalignErr
`endif
    );

    modport slave (
        input  WB_MEM, MEM_MEM, WN_MEM, RD2_MEM, DataOut_MEM,
        output WB_WB, WN_WB, RDATA_WB, ALU_WB, WData_WB
`ifdef MEM_ALIGN_CHK_EN
        , output Misalign_WB, MisalignErr
`endif
    );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Desc     : MEM stage data RAM plus MEM/WB pipeline register. Define
//            MEM_ALIGN_CHK_EN to add misaligned-access detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int DEPTH_LOG2 = 8
) (
    input  wire logic       Clk,
    input  wire logic       Rst,
    mem_wb_stage_if.slave   bus
);
    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           ram [c_DEPTH];
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_mem_write;
    logic                  w_mem_read;
    logic                  w_store_en;
    logic                  w_load_en;
    logic                  w_misalign;

    logic [1:0]  wb_d,    wb_q;
    logic [4:0]  wn_d,    wn_q;
    logic [31:0] rdata_d, rdata_q;
    logic [31:0] alu_d,   alu_q;

    assign w_idx       = bus.DataOut_MEM[DEPTH_LOG2+1:2];
    assign w_mem_write = bus.MEM_MEM[1];
    assign w_mem_read  = bus.MEM_MEM[0];

`ifdef MEM_ALIGN_CHK_EN
    logic misalign_d, misalign_q;
    logic err_d,      err_q;
    logic w_unused_bits;

    assign w_misalign    = (w_mem_write | w_mem_read) & (bus.DataOut_MEM[1:0] != 2'b00);
    assign w_unused_bits = ^bus.DataOut_MEM[31:DEPTH_LOG2+2];
`else
    logic w_unused_bits;

    assign w_misalign    = 1'b0;
    assign w_unused_bits = ^{bus.DataOut_MEM[31:DEPTH_LOG2+2], bus.DataOut_MEM[1:0]};
`endif

    // A store in a reset cycle is dropped; the RAM itself is never cleared.
    assign w_store_en = ~Rst & w_mem_write & ~w_misalign;
    assign w_load_en  = w_mem_read & ~w_misalign;

    always_comb begin
        wb_d    = bus.WB_MEM;
        wn_d    = bus.WN_MEM;
        alu_d   = bus.DataOut_MEM;
        rdata_d = w_load_en ? ram[w_idx] : 32'b0;
        if (w_misalign && w_mem_read) begin
            wb_d[1] = 1'b0;
        end
        if (Rst) begin
            wb_d    = 2'b0;
            wn_d    = 5'b0;
            alu_d   = 32'b0;
            rdata_d = 32'b0;
        end
    end

    // Read-before-write: rdata_d samples the word ahead of this edge's store.
    always_ff @(posedge Clk) begin
        if (w_store_en) begin
            ram[w_idx] <= bus.RD2_MEM;
        end
    end

    always_ff @(posedge Clk) begin
        wb_q    <= wb_d;
        wn_q    <= wn_d;
        rdata_q <= rdata_d;
        alu_q   <= alu_d;
    end

    assign bus.WB_WB    = wb_q;
    assign bus.WN_WB    = wn_q;
    assign bus.RDATA_WB = rdata_q;
    assign bus.ALU_WB   = alu_q;
    assign bus.WData_WB = wb_q[0] ? rdata_q : alu_q;

`ifdef MEM_ALIGN_CHK_EN
    always_comb begin
        misalign_d = w_misalign;
        err_d      = err_q | w_misalign;
        if (Rst) begin
            misalign_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        misalign_q <= misalign_d;
        err_q      <= err_d;
    end

    assign bus.Misalign_WB = misalign_q;
    assign bus.MisalignErr = err_q;
`endif

endmodule

`default_nettype wire
